// File: rtl/acc_prog_loader.sv
// Byte-stream program loader for an accumulator core: receives a length/payload/checksum
// frame, writes 32-bit words into instruction memory, and releases the core only after a good checksum.
module acc_prog_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic          restart,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          core_run,
  output logic          err,
  output logic [AW:0]   words_loaded
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    RUN   = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [1:0]  lane_r;
  logic [AW:0] word_idx_r;
  logic [AW:0] len_r;
  logic [7:0]  csum_r;
  logic [23:0] asm_r;
  logic        accept_s;
  logic        len_ok_s;
  logic        last_word_s;

  function automatic logic [7:0] csum_next(input logic [7:0] c, input logic [7:0] b);
    return c ^ b;
  endfunction

  // Handshake decode and next-state selection
  always_comb begin
    state_s     = state_r;
    in_ready    = 1'b0;
    len_ok_s    = (in_data != 8'd0) && ({24'd0, in_data} <= 32'(DEPTH));
    last_word_s = ((word_idx_r + {{AW{1'b0}}, 1'b1}) == len_r);
    case (state_r)
      IDLE, LOAD, CHECK: in_ready = 1'b1;
      default:           in_ready = 1'b0;
    endcase
    accept_s = in_valid & in_ready;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = len_ok_s ? LOAD : ERR;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (accept_s && (lane_r == 2'd3) && last_word_s) begin
          state_s = CHECK;
        end else begin
          state_s = LOAD;
        end
      end
      CHECK: begin
        if (accept_s) begin
          state_s = (in_data == csum_r) ? RUN : ERR;
        end else begin
          state_s = CHECK;
        end
      end
      RUN, ERR: begin
        if (restart) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Word assembly, checksum, memory write strobe and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_r       <= 2'd0;
      word_idx_r   <= '0;
      len_r        <= '0;
      csum_r       <= 8'd0;
      asm_r        <= 24'd0;
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= 32'd0;
      core_run     <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_we  <= 1'b0;
      core_run <= (state_s == RUN);
      err      <= (state_s == ERR);
      if ((state_r != IDLE) && (state_s == IDLE)) begin
        lane_r       <= 2'd0;
        word_idx_r   <= '0;
        len_r        <= '0;
        csum_r       <= 8'd0;
        words_loaded <= '0;
      end else if (accept_s) begin
        case (state_r)
          IDLE: len_r <= in_data[AW:0];
          LOAD: begin
            csum_r <= csum_next(csum_r, in_data);
            lane_r <= lane_r + 2'd1;
            case (lane_r)
              2'd0: asm_r[7:0]   <= in_data;
              2'd1: asm_r[15:8]  <= in_data;
              2'd2: asm_r[23:16] <= in_data;
              default: begin
                // Fourth byte completes the word; write it out directly
                imem_we      <= 1'b1;
                imem_waddr   <= word_idx_r[AW-1:0];
                imem_wdata   <= {in_data, asm_r};
                words_loaded <= words_loaded + {{AW{1'b0}}, 1'b1};
                word_idx_r   <= word_idx_r + {{AW{1'b0}}, 1'b1};
              end
            endcase
          end
          default: ;
        endcase
      end else begin
        lane_r <= lane_r;
      end
    end
  end

endmodule

// File: tb/tb_acc_prog_loader.sv
// Self-checking bench for acc_prog_loader: table of frame scenarios with random payloads
// compared against a frame-level model, plus hand sequences for latency and mid-word reset.
module tb_acc_prog_loader;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          restart;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          core_run;
  logic          err;
  logic [AW:0]   words_loaded;

  int tests = 0;
  int fails = 0;
  logic [AW+31:0] got_q[$];
  logic [AW+31:0] exp_q[$];

  acc_prog_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .restart(restart), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .core_run(core_run),
    .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) got_q.push_back({imem_waddr, imem_wdata});
  end

  typedef struct {
    logic [7:0] len;
    bit         bad_csum;
    bit         gaps;
    bit         exp_run;
    bit         exp_err;
    int         exp_words;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_wr%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    int w;
    n = gaps ? $urandom_range(0, 3) : 0;
    repeat (n) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got in_ready 0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_restart(input string tag);
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    @(negedge clk);
    check({tag, "_rs_err"}, 64'(err), 64'd0);
    check({tag, "_rs_run"}, 64'(core_run), 64'd0);
    check({tag, "_rs_words"}, 64'(words_loaded), 64'd0);
    check({tag, "_rs_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  // Model: builds the frame and the word writes it should produce
  task automatic send_frame(input int n, input bit bad, input bit gaps);
    logic [7:0] pl[$];
    logic [7:0] cs;
    cs = 8'd0;
    for (int i = 0; i < 4 * n; i++) begin
      pl.push_back(8'($urandom));
      cs = cs ^ pl[i];
    end
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({AW'(i), pl[4*i+3], pl[4*i+2], pl[4*i+1], pl[4*i]});
    end
    if (bad) cs = cs ^ 8'($urandom_range(1, 255));
    send_byte(8'(n), gaps);
    for (int i = 0; i < 4 * n; i++) send_byte(pl[i], gaps);
    send_byte(cs, gaps);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{8'd1,  1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[1] = '{8'd2,  1'b1, 1'b0, 1'b0, 1'b1, 2};
    vecs[2] = '{8'd2,  1'b0, 1'b1, 1'b1, 1'b0, 2};
    vecs[3] = '{8'd16, 1'b0, 1'b0, 1'b1, 1'b0, 16};
    vecs[4] = '{8'd16, 1'b0, 1'b1, 1'b1, 1'b0, 16};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[6] = '{8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[7] = '{8'd5,  1'b0, 1'b1, 1'b1, 1'b0, 5};
    vecs[8] = '{8'd3,  1'b1, 1'b1, 1'b0, 1'b1, 3};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'd0; restart = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_we", 64'(imem_we), 64'd0);
    check("rst_waddr", 64'(imem_waddr), 64'd0);
    check("rst_wdata", 64'(imem_wdata), 64'd0);
    check("rst_run", 64'(core_run), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_words", 64'(words_loaded), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 64'(in_ready), 64'd1);

    // Single-word frame with exact write latency
    send_byte(8'h01, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h00, 1'b0);
    @(negedge clk);
    check("h_we", 64'(imem_we), 64'd1);
    check("h_waddr", 64'(imem_waddr), 64'd0);
    check("h_wdata", 64'(imem_wdata), 64'h00050003);
    check("h_words", 64'(words_loaded), 64'd1);
    check("h_run_early", 64'(core_run), 64'd0);
    @(posedge clk); #1;
    check("h_we_pulse", 64'(imem_we), 64'd0);
    send_byte(8'h06, 1'b0);
    @(negedge clk);
    check("h_run", 64'(core_run), 64'd1);
    check("h_ready", 64'(in_ready), 64'd0);
    exp_q.push_back({AW'(0), 32'h00050003});
    compare_writes("h");
    @(posedge clk); #1;
    pulse_restart("h");

    for (int v = 0; v < 9; v++) begin
      string tag;
      tag = $sformatf("v%0d", v);
      if (vecs[v].len == 8'd0 || vecs[v].len > 8'(DEPTH)) begin
        send_byte(vecs[v].len, vecs[v].gaps);
      end else begin
        send_frame(int'(vecs[v].len), vecs[v].bad_csum, vecs[v].gaps);
      end
      in_valid = 1'b1;
      repeat (4) begin
        in_data = 8'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      check({tag, "_run"}, 64'(core_run), 64'(vecs[v].exp_run));
      check({tag, "_err"}, 64'(err), 64'(vecs[v].exp_err));
      check({tag, "_words"}, 64'(words_loaded), 64'(vecs[v].exp_words));
      check({tag, "_ready"}, 64'(in_ready), 64'd0);
      compare_writes(tag);
      @(posedge clk); #1;
      pulse_restart(tag);
    end

    // Reset in the middle of a word abandons the frame
    send_byte(8'd2, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mr_we", 64'(imem_we), 64'd0);
    check("mr_words", 64'(words_loaded), 64'd0);
    check("mr_run", 64'(core_run), 64'd0);
    check("mr_err", 64'(err), 64'd0);
    check("mr_wdata", 64'(imem_wdata), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mr_ready", 64'(in_ready), 64'd1);
    compare_writes("mr");
    send_frame(3, 1'b0, 1'b1);
    @(negedge clk);
    check("mr2_run", 64'(core_run), 64'd1);
    check("mr2_words", 64'(words_loaded), 64'd3);
    compare_writes("mr2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
